// File: rtl/rf_pkg.sv
// Shared constants for the integer register file and its scoreboard.
// ABI register numbers and reset defaults live here.
package rf_pkg;

    localparam int XLEN_DEF = 32;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 2;
    localparam int REG_GP   = 3;

    localparam logic [31:0] SP_INIT_DEF = 32'h7fffeffc;
    localparam logic [31:0] GP_INIT_DEF = 32'h10008000;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register marks an in-flight
// producer; a new issue beats a completing write, flush beats both.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NREGS  = 32,
    parameter  int NREAD  = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    input  logic [NREAD*AW-1:0] raddr,
    output logic [NREGS-1:0]    pend,
    output logic [NREAD-1:0]    rbusy
);

    logic [NREGS-1:0] pend_nxt;
    logic [AW-1:0]    ra;

    // Per-register next state: set wins over clear; x0 never pending.
    always_comb begin
        pend_nxt = pend;
        for (int i = 1; i < NREGS; i++) begin
            if (iss_valid && iss_rd == AW'(i)) begin
                pend_nxt[i] = 1'b1;
            end else if (we && waddr == AW'(i)) begin
                pend_nxt[i] = 1'b0;
            end
        end
        pend_nxt[REG_ZERO] = 1'b0;
    end

    // Pending vector register; flush wipes every in-flight producer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else if (flush) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    // Busy per read port; with bypass a completing write unblocks now.
    always_comb begin
        rbusy = '0;
        ra    = '0;
        for (int k = 0; k < NREAD; k++) begin
            ra = raddr[k*AW +: AW];
            rbusy[k] = pend[ra] &
                       ~((BYPASS != 0) & we & (waddr == ra));
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with asynchronous read ports, one write port,
// optional write-to-read bypass and a pending-write scoreboard.
module regfile_sb
    import rf_pkg::*;
#(
    parameter  int               XLEN    = XLEN_DEF,
    parameter  int               NREGS   = 32,
    parameter  int               NREAD   = 2,
    parameter  logic [XLEN-1:0]  SP_INIT = SP_INIT_DEF,
    parameter  logic [XLEN-1:0]  GP_INIT = GP_INIT_DEF,
    parameter  int               BYPASS  = 1,
    localparam int               AW      = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [NREAD*AW-1:0]   raddr,
    output logic [NREAD*XLEN-1:0] rdata,
    output logic [NREAD-1:0]      rbusy,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    input  logic                  flush,
    output logic [NREGS-1:0]      pend
);

    logic [XLEN-1:0] rf [NREGS];
    logic [AW-1:0]   ra;

    // Data array: ABI reset values, writes to x0 are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
            rf[REG_SP] <= SP_INIT;
            rf[REG_GP] <= GP_INIT;
        end else if (we && waddr != AW'(REG_ZERO)) begin
            rf[waddr] <= wdata;
        end
    end

    // Read muxes: x0 reads zero, then bypass, then the array.
    always_comb begin
        rdata = '0;
        ra    = '0;
        for (int k = 0; k < NREAD; k++) begin
            ra = raddr[k*AW +: AW];
            if (ra == AW'(REG_ZERO)) begin
                rdata[k*XLEN +: XLEN] = '0;
            end else if (BYPASS != 0 && we && waddr == ra) begin
                rdata[k*XLEN +: XLEN] = wdata;
            end else begin
                rdata[k*XLEN +: XLEN] = rf[ra];
            end
        end
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .NREAD  (NREAD),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .waddr     (waddr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .raddr     (raddr),
        .pend      (pend),
        .rbusy     (rbusy)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, corner sequences,
// then random traffic against an array-based reference model.
module tb_regfile_sb;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        flush;
    logic [31:0] pend;
    logic [63:0] nb_rdata;
    logic [1:0]  nb_rbusy;
    logic [31:0] nb_pend;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_rf [32];
    bit          m_p  [32];

    regfile_sb dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .pend      (pend)
    );

    regfile_sb #(.BYPASS(0)) dut_nb (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr),
        .rdata     (nb_rdata),
        .rbusy     (nb_rbusy),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .pend      (nb_pend)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] we, waddr, wdata, iv, ird, fl, r0, r1;
        logic [31:0] e0, e1, eb, ep;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_rf[i] = 32'h0;
            m_p[i]  = 1'b0;
        end
        m_rf[2] = 32'h7fffeffc;
        m_rf[3] = 32'h10008000;
    endtask

    // Reference update for one rising edge, from the current inputs.
    task automatic m_clock();
        if (we && waddr != 0) m_rf[waddr] = wdata;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_p[i] = 1'b0;
        end else begin
            if (we) m_p[waddr] = 1'b0;
            if (iss_valid && iss_rd != 0) m_p[iss_rd] = 1'b1;
        end
    endtask

    task automatic tick();
        m_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 0; waddr = 0; wdata = 0;
        iss_valid = 0; iss_rd = 0; flush = 0;
    endtask

    function automatic logic [31:0] m_pend();
        logic [31:0] v;
        v = 0;
        for (int i = 0; i < 32; i++) v[i] = m_p[i];
        return v;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a,
                                           input bit byp);
        if (a == 0) return 32'h0;
        if (byp && we && waddr == a) return wdata;
        return m_rf[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a, input bit byp);
        return m_p[a] && !(byp && we && waddr == a);
    endfunction

    initial begin
        logic [4:0] r0, r1;

        tbl[0]  = '{0, 0, 0, 0, 0, 0, 2, 3,
                    32'h7fffeffc, 32'h10008000, 0, 0};
        tbl[1]  = '{1, 0, 32'hDEADBEEF, 1, 0, 0, 0, 5, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 7, 32'h12345678, 0, 0, 0, 7, 7,
                    32'h12345678, 32'h12345678, 0, 0};
        tbl[4]  = '{0, 0, 0, 1, 9, 0, 7, 9, 32'h12345678, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 9, 9, 0, 0, 3, 32'h200};
        tbl[6]  = '{1, 9, 32'hA5, 0, 0, 0, 9, 9,
                    32'hA5, 32'hA5, 0, 32'h200};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 9, 9, 32'hA5, 32'hA5, 0, 0};
        tbl[8]  = '{1, 4, 1, 1, 4, 0, 4, 2, 1, 32'h7fffeffc, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 4, 4, 1, 1, 3, 32'h10};
        tbl[10] = '{1, 4, 2, 1, 4, 1, 4, 3, 2, 32'h10008000, 0, 32'h10};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 4, 0, 2, 0, 0, 0};
        tbl[12] = '{1, 2, 32'hCAFE, 0, 0, 0, 2, 3,
                    32'hCAFE, 32'h10008000, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 2, 7,
                    32'hCAFE, 32'h12345678, 0, 0};

        reset = 1'b1;
        idle();
        raddr = 0;
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed table, one cycle per row.
        for (int n = 0; n < 14; n++) begin
            we        = tbl[n].we[0];
            waddr     = tbl[n].waddr[4:0];
            wdata     = tbl[n].wdata;
            iss_valid = tbl[n].iv[0];
            iss_rd    = tbl[n].ird[4:0];
            flush     = tbl[n].fl[0];
            raddr     = {tbl[n].r1[4:0], tbl[n].r0[4:0]};
            #3;
            chk($sformatf("tbl%0d rdata0", n), rdata[31:0], tbl[n].e0);
            chk($sformatf("tbl%0d rdata1", n), rdata[63:32], tbl[n].e1);
            chk($sformatf("tbl%0d rbusy", n), {30'b0, rbusy}, tbl[n].eb);
            chk($sformatf("tbl%0d pend", n), pend, tbl[n].ep);
            chk($sformatf("tbl%0d model", n), m_pend(), tbl[n].ep);
            tick();
        end

        // Bypass disabled: write visible only after the edge.
        idle();
        we = 1; waddr = 11; wdata = 32'h11111111;
        raddr = {5'd11, 5'd11};
        #3;
        chk("byp rdata0", rdata[31:0], 32'h11111111);
        chk("nobyp rdata0 old", nb_rdata[31:0], 32'h0);
        tick();
        idle();
        iss_valid = 1; iss_rd = 11;
        #3;
        chk("nobyp rdata0 new", nb_rdata[31:0], 32'h11111111);
        tick();
        idle();
        we = 1; waddr = 11; wdata = 32'h2222;
        #3;
        chk("byp rbusy wb", {31'b0, rbusy[0]}, 32'h0);
        chk("nobyp rbusy wb", {31'b0, nb_rbusy[0]}, 32'h1);
        tick();

        // Async reset between edges with a write in flight.
        idle();
        we = 1; waddr = 6; wdata = 32'h55;
        iss_valid = 1; iss_rd = 6;
        tick();
        idle();
        raddr = {5'd2, 5'd6};
        #1;
        chk("pre-reset pend6", {31'b0, pend[6]}, 32'h1);
        chk("pre-reset x6", rdata[31:0], 32'h55);
        we = 1; waddr = 6; wdata = 32'h77;
        #2;
        reset = 1'b1;
        we = 0;
        #1;
        chk("async pend", pend, 32'h0);
        chk("async x6", rdata[31:0], 32'h0);
        chk("async x2", rdata[63:32], 32'h7fffeffc);
        #1;
        reset = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        chk("post-reset x6", rdata[31:0], 32'h0);

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            we        = $urandom_range(0, 1);
            waddr     = 5'($urandom_range(0, 15));
            wdata     = $urandom;
            iss_valid = $urandom_range(0, 1);
            iss_rd    = 5'($urandom_range(0, 15));
            flush     = ($urandom_range(0, 19) == 0);
            r0        = 5'($urandom_range(0, 15));
            r1        = 5'($urandom_range(0, 31));
            raddr     = {r1, r0};
            #3;
            chk("rnd rdata0", rdata[31:0], m_read(r0, 1));
            chk("rnd rdata1", rdata[63:32], m_read(r1, 1));
            chk("rnd rbusy", {30'b0, rbusy},
                {30'b0, m_busy(r1, 1), m_busy(r0, 1)});
            chk("rnd pend", pend, m_pend());
            chk("rnd nb rdata0", nb_rdata[31:0], m_read(r0, 0));
            chk("rnd nb rbusy", {30'b0, nb_rbusy},
                {30'b0, m_busy(r1, 0), m_busy(r0, 0)});
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
